// File: rtl/and_txn_driver_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// and_txn_driver_if : request, DUT-drive and result signals of and_txn_driver
// Revision: 1.0
// ---------------------------------------------------------------------------
interface and_txn_driver_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] a_o;
  logic [WIDTH-1:0] b_o;
  logic [WIDTH-1:0] y_i;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_y;
  logic             out_err;
  logic [15:0]      pass_cnt;
  logic [15:0]      err_cnt;
  logic             busy;

  modport master (
    input  in_valid, in_a, in_b, y_i, out_ready,
    output in_ready, a_o, b_o, out_valid, out_a, out_b, out_y, out_err,
           pass_cnt, err_cnt, busy
  );

  modport slave (
    output in_valid, in_a, in_b, y_i, out_ready,
    input  in_ready, a_o, b_o, out_valid, out_a, out_b, out_y, out_err,
           pass_cnt, err_cnt, busy
  );
endinterface
`default_nettype wire

// File: rtl/and_txn_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// and_txn_driver : queues operand pairs, drives them to an AND DUT, samples y
// after SETTLE cycles and reports each result with a correctness flag.
// Revision: 1.0
// ---------------------------------------------------------------------------
module and_txn_driver #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input wire               clk,
  input wire               rst,
  and_txn_driver_if.master bus
);

  localparam int C_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int C_CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [C_CW-1:0] C_SETTLE_LAST = C_CW'(SETTLE - 1);
  localparam logic [C_AW:0]   C_DEPTH       = (C_AW + 1)'(DEPTH);
  localparam logic [15:0]     C_CNT_MAX     = 16'hFFFF;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  logic [2*WIDTH-1:0] r_mem [DEPTH];
  logic [C_AW-1:0]    r_wr_ptr;
  logic [C_AW-1:0]    r_rd_ptr;
  logic [C_AW:0]      r_count;

  logic [1:0]         r_state;
  logic [C_CW-1:0]    r_settle;
  logic [WIDTH-1:0]   r_a_drv;
  logic [WIDTH-1:0]   r_b_drv;
  logic [WIDTH-1:0]   r_out_a;
  logic [WIDTH-1:0]   r_out_b;
  logic [WIDTH-1:0]   r_out_y;
  logic               r_out_err;
  logic [15:0]        r_pass_cnt;
  logic [15:0]        r_err_cnt;

  logic               w_full;
  logic               w_empty;
  logic               w_in_ready;
  logic               w_push;
  logic               w_pop;
  logic [2*WIDTH-1:0] w_head;

  // Readiness depends only on occupancy, so a same-cycle pop never frees a slot early.
  assign w_full     = (r_count == C_DEPTH);
  assign w_empty    = (r_count == '0);
  assign w_in_ready = !w_full && !rst;
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_pop      = (r_state == S_IDLE) && !w_empty;
  assign w_head     = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.in_a, bus.in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (C_AW + 1)'(1);
        2'b01:   r_count <= r_count - (C_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_settle   <= '0;
      r_a_drv    <= '0;
      r_b_drv    <= '0;
      r_out_a    <= '0;
      r_out_b    <= '0;
      r_out_y    <= '0;
      r_out_err  <= 1'b0;
      r_pass_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_a_drv  <= w_head[2*WIDTH-1:WIDTH];
            r_b_drv  <= w_head[WIDTH-1:0];
            r_settle <= '0;
            r_state  <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          r_settle <= r_settle + C_CW'(1);
          if (r_settle == C_SETTLE_LAST) begin
            r_out_a   <= r_a_drv;
            r_out_b   <= r_b_drv;
            r_out_y   <= bus.y_i;
            r_out_err <= (bus.y_i != (r_a_drv & r_b_drv));
            r_state   <= S_REPORT;
          end
        end
        S_REPORT: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
            if (r_out_err) begin
              if (r_err_cnt != C_CNT_MAX) begin
                r_err_cnt <= r_err_cnt + 16'd1;
              end
            end else begin
              if (r_pass_cnt != C_CNT_MAX) begin
                r_pass_cnt <= r_pass_cnt + 16'd1;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.a_o       = r_a_drv;
  assign bus.b_o       = r_b_drv;
  assign bus.out_valid = (r_state == S_REPORT);
  assign bus.out_a     = r_out_a;
  assign bus.out_b     = r_out_b;
  assign bus.out_y     = r_out_y;
  assign bus.out_err   = r_out_err;
  assign bus.pass_cnt  = r_pass_cnt;
  assign bus.err_cnt   = r_err_cnt;
  assign bus.busy      = (r_state != S_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_and_txn_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_and_txn_driver : directed + random bench with a queue-based result model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_and_txn_driver;

  localparam int WIDTH  = 4;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  and_txn_driver_if #(.WIDTH(WIDTH)) bus ();

  logic             fault_en  = 1'b0;
  logic [WIDTH-1:0] fault_val = '0;
  assign bus.y_i = fault_en ? fault_val : (bus.a_o & bus.b_o);

  and_txn_driver #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .SETTLE (SETTLE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Each entry: {a, b, y the DUT model will present}
  logic [3*WIDTH-1:0] m_q[$];
  int               m_pass;
  int               m_err;
  logic             hold_prev;
  logic [WIDTH-1:0] prev_a, prev_b, prev_y;
  logic             prev_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock edge: drive inputs at negedge, score the handshakes of the coming edge.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic ordy, output logic accepted);
    logic [3*WIDTH-1:0] e;
    logic [WIDTH-1:0]   ea, eb, ey;
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = ordy;
    #1;
    if (hold_prev) begin
      check_val("hold_valid", bus.out_valid, 1);
      check_val("hold_out_a", bus.out_a, prev_a);
      check_val("hold_out_b", bus.out_b, prev_b);
      check_val("hold_out_y", bus.out_y, prev_y);
      check_val("hold_out_err", bus.out_err, prev_err);
    end
    if (bus.out_valid && ordy) begin
      if (m_q.size() == 0) begin
        check_val("unexpected_result", 1, 0);
      end else begin
        e  = m_q.pop_front();
        ea = e[3*WIDTH-1:2*WIDTH];
        eb = e[2*WIDTH-1:WIDTH];
        ey = e[WIDTH-1:0];
        check_val("out_a", bus.out_a, ea);
        check_val("out_b", bus.out_b, eb);
        check_val("out_y", bus.out_y, ey);
        check_val("out_err", bus.out_err, ey != (ea & eb));
        if (ey != (ea & eb)) m_err = (m_err < 65535) ? m_err + 1 : m_err;
        else                 m_pass = (m_pass < 65535) ? m_pass + 1 : m_pass;
      end
    end
    hold_prev = bus.out_valid && !ordy;
    prev_a    = bus.out_a;
    prev_b    = bus.out_b;
    prev_y    = bus.out_y;
    prev_err  = bus.out_err;
    accepted  = v && bus.in_ready;
    if (accepted) m_q.push_back({a, b, fault_en ? fault_val : (a & b)});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
    m_q.delete();
    m_pass    = 0;
    m_err     = 0;
    hold_prev = 1'b0;
  endtask

  task automatic drain(input int budget);
    int   n;
    logic acc;
    n = 0;
    while ((m_q.size() != 0 || bus.busy) && n < budget) begin
      cycle(1'b0, '0, '0, 1'b1, acc);
      n++;
    end
    check_val("drain_done", (n < budget), 1);
  endtask

  task automatic check_counters();
    check_val("pass_cnt", bus.pass_cnt, m_pass);
    check_val("err_cnt", bus.err_cnt, m_err);
  endtask

  initial begin
    logic             acc;
    logic [WIDTH-1:0] ra, rb;
    hold_prev = 1'b0;
    m_pass    = 0;
    m_err     = 0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);

    // Reset state
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", bus.in_ready, 0);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_a_o", bus.a_o, 0);
    check_val("rst_b_o", bus.b_o, 0);
    check_val("rst_out_y", bus.out_y, 0);
    check_val("rst_busy", bus.busy, 0);
    do_reset(1);
    #1;
    check_val("post_rst_in_ready", bus.in_ready, 1);
    check_counters();

    // Single pass with latency
    cycle(1'b1, 4'b0100, 4'b1100, 1'b1, acc);
    check_val("lat_e0", bus.out_valid, 0);
    cycle(1'b0, '0, '0, 1'b1, acc);
    check_val("lat_e1", bus.out_valid, 0);
    cycle(1'b0, '0, '0, 1'b1, acc);
    check_val("lat_e2", bus.out_valid, 0);
    check_val("drive_a_o", bus.a_o, 4'b0100);
    check_val("drive_b_o", bus.b_o, 4'b1100);
    cycle(1'b0, '0, '0, 1'b1, acc);
    check_val("lat_e3", bus.out_valid, 1);
    check_val("single_out_y", bus.out_y, 4'b0100);
    check_val("single_out_err", bus.out_err, 0);
    drain(20);
    check_val("single_pass_cnt", bus.pass_cnt, 1);
    check_counters();

    // Faulty DUT
    do_reset(1);
    fault_en  = 1'b1;
    fault_val = 4'b1111;
    cycle(1'b1, 4'b0011, 4'b0101, 1'b1, acc);
    drain(20);
    check_val("fault_err_cnt", bus.err_cnt, 1);
    check_val("fault_pass_cnt", bus.pass_cnt, 0);
    fault_en = 1'b0;

    // Backpressure until full, then release
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      #1;
      check_val("full_in_ready", bus.in_ready, (i < 5));
      cycle(1'b1, WIDTH'(i + 3), WIDTH'(4'hF - i), 1'b0, acc);
    end
    repeat (4) cycle(1'b0, '0, '0, 1'b0, acc);
    check_val("full_out_valid", bus.out_valid, 1);
    check_val("full_in_ready_held", bus.in_ready, 0);
    drain(60);
    check_val("full_pass_cnt", bus.pass_cnt, 5);
    check_counters();

    // 8 random requests, ready consumer
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      ra  = WIDTH'($urandom);
      rb  = WIDTH'($urandom);
      acc = 1'b0;
      for (int t = 0; t < 50 && !acc; t++) cycle(1'b1, ra, rb, 1'b1, acc);
      check_val("tput_accept", acc, 1);
    end
    drain(60);
    check_val("tput_pass_cnt", bus.pass_cnt, 8);
    check_val("tput_err_cnt", bus.err_cnt, 0);
    check_val("tput_busy", bus.busy, 0);

    // Random soak: random valid/ready, faulty phases only while idle
    for (int blk = 0; blk < 4; blk++) begin
      fault_en  = blk[0];
      fault_val = WIDTH'($urandom);
      for (int i = 0; i < 80; i++) begin
        cycle(1'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), acc);
      end
      drain(200);
      check_counters();
    end
    fault_en = 1'b0;

    // Reset while driving with two entries queued
    do_reset(1);
    cycle(1'b1, 4'h9, 4'hC, 1'b0, acc);
    cycle(1'b1, 4'h7, 4'h3, 1'b0, acc);
    cycle(1'b1, 4'hF, 4'h5, 1'b0, acc);
    check_val("pre_rst_busy", bus.busy, 1);
    check_val("pre_rst_a_o", bus.a_o, 4'h9);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_q.delete();
    m_pass    = 0;
    m_err     = 0;
    hold_prev = 1'b0;
    #1;
    check_val("mid_rst_in_ready", bus.in_ready, 1);
    check_val("mid_rst_out_valid", bus.out_valid, 0);
    check_val("mid_rst_a_o", bus.a_o, 0);
    check_val("mid_rst_b_o", bus.b_o, 0);
    check_val("mid_rst_busy", bus.busy, 0);
    check_counters();
    for (int i = 0; i < 10; i++) begin
      check_val("no_ghost_result", bus.out_valid, 0);
      cycle(1'b0, '0, '0, 1'b1, acc);
    end
    check_counters();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/and_txn_driver.md
AND_TXN_DRIVER -- requirements
Module: and_txn_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width of the AND DUT.
REQ-002 SHALL have parameter DEPTH, default 4, request FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter SETTLE, default 2, cycles operands are held before y is sampled (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  request transaction present.
REQ-007 SHALL have port in_ready  output  1  request accepted when high with in_valid.
REQ-008 SHALL have port in_a  input  WIDTH  operand a of request.
REQ-009 SHALL have port in_b  input  WIDTH  operand b of request.
REQ-010 SHALL have port a_o  output  WIDTH  registered operand a driven to the DUT.
REQ-011 SHALL have port b_o  output  WIDTH  registered operand b driven to the DUT.
REQ-012 SHALL have port y_i  input  WIDTH  DUT result.
REQ-013 SHALL have port out_valid  output  1  result transaction present.
REQ-014 SHALL have port out_ready  input  1  consumer accepts result.
REQ-015 SHALL have ports out_a, out_b, out_y  output  WIDTH each  operands and sampled y of the result.
REQ-016 SHALL have port out_err  output  1  high when out_y != out_a & out_b.
REQ-017 SHALL have ports pass_cnt, err_cnt  output  16 each  completed-transaction counters.
REQ-018 SHALL have port busy  output  1  high when the FSM is not in IDLE or the FIFO is non-empty.

Function
REQ-019 SHALL push {in_a,in_b} into the FIFO on an edge with in_valid && in_ready; in_ready = !full && !rst, so no push when full even if a pop happens in the same cycle.
REQ-020 SHALL implement FSM states IDLE, DRIVE, REPORT.
REQ-021 IDLE: if the FIFO is non-empty, SHALL pop the head into a_o/b_o, clear settle counter, and go to DRIVE; otherwise stay.
REQ-022 DRIVE: SHALL increment the settle counter each cycle; on the edge where counter == SETTLE-1, SHALL capture y_i into out_y, copy a_o/b_o into out_a/out_b, set out_err = (y_i != (a_o & b_o)), and go to REPORT.
REQ-023 REPORT: out_valid SHALL be 1 and all out_* SHALL be stable until out_valid && out_ready; on that edge go to IDLE and increment pass_cnt (out_err=0) or err_cnt (out_err=1).
REQ-024 Counters SHALL saturate at 16'hFFFF.
REQ-025 a_o/b_o SHALL change only on a pop edge and hold otherwise.
REQ-026 Latency: push into an empty FIFO with FSM in IDLE on edge N SHALL give out_valid high after edge N+SETTLE+1.
REQ-027 Push and pop in the same cycle (FIFO not full) SHALL both take effect; occupancy unchanged.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH.
REQ-029 Results SHALL be delivered in request order.

Reset
REQ-030 On an edge with rst=1: FIFO empty, FSM IDLE, settle counter 0, a_o=b_o=0, out_valid=0, out_a/out_b/out_y=0, out_err=0, pass_cnt=err_cnt=0, busy=0.
REQ-031 Reset mid-operation SHALL discard queued and in-flight transactions with no counter update; in_ready SHALL be 1 on the first cycle after rst falls.

Verification
REQ-032 Single pass: push a=4'b0100, b=4'b1100 at edge 0, model y=a&b, out_ready=1 -> out_valid after edge 3, out_y=4'b0100, out_err=0, then pass_cnt=1.
REQ-033 Fault: push a=4'b0011, b=4'b0101, force y_i=4'b1111 -> out_y=4'b1111, out_err=1, then err_cnt=1, pass_cnt=0.
REQ-034 Backpressure/full: out_ready=0, push 6 requests back-to-back -> 5 accepted (1 in REPORT, 4 in FIFO), in_ready=0, out_* stable; raise out_ready -> all 5 results delivered in order.
REQ-035 Throughput/order: 8 random requests, out_ready=1, correct DUT -> 8 results in order, pass_cnt=8, err_cnt=0, busy=0 at end.
REQ-036 Reset mid-DRIVE: assert rst for 1 cycle while in DRIVE with 2 entries queued -> out_valid=0, counters 0, a_o=b_o=0, busy=0, in_ready=1 next cycle; no result appears later.
